// File: rtl/aes_pkg.sv
// Shared AES S-box constants, scheduler state encodings and the GF(2^8) helpers
// used by the lane scheduler and its S-box lanes.
package aes_pkg;

  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
  localparam int         STATE_BYTES   = 16;
  localparam int         WORD_BYTES    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_S = 2'd1,
    RUN_K = 2'd2
  } sched_state_t;

  // Which requester wins when both are valid in IDLE.
  typedef enum logic {
    RR_S = 1'b0,
    RR_K = 1'b1
  } rr_t;

  function automatic int beats_s(input int lanes);
    return STATE_BYTES / lanes;
  endfunction

  function automatic int beats_k(input int lanes);
    return WORD_BYTES / lanes;
  endfunction

  // A single-beat job still needs a 1-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// One combinational AES S-box lane: multiplicative inverse in GF(2^8) computed
// as x^254 (which maps 0 to 0), followed by the affine map plus 0x63.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for x^254: 2,3,6,12,15,30,60,120,240,252,254.
  assign x2   = gf_mul(din, din);
  assign x3   = gf_mul(x2, din);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  // NOTE: every output bit gets a default before the loop so no latch can be inferred.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      dout[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ SBOX_AFFINE_C[i];
    end
  end

endmodule

// File: rtl/sbox_lane_scheduler.sv
// Round-robin scheduler sharing LANES S-box lanes between a 128-bit SubBytes
// job and a 32-bit SubWord job, processing LANES bytes per beat in place.
module sbox_lane_scheduler
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         s_done,
  output logic [127:0] s_result,
  input  logic         k_valid,
  output logic         k_ready,
  input  logic [31:0]  k_data,
  output logic         k_done,
  output logic [31:0]  k_result,
  output logic         busy
);

  localparam int BEATS_S = beats_s(LANES);
  localparam int BEATS_K = beats_k(LANES);
  localparam int CNT_W   = cnt_width(BEATS_S);
  localparam int LANE_W  = 8 * LANES;

  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(BEATS_S - 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BEATS_K - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("sbox_lane_scheduler: LANES must be 1, 2 or 4");
  end

  sched_state_t     state;
  rr_t              rr_prio;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     work;
  logic [127:0]     work_next;
  logic [6:0]       base;
  logic [LANE_W-1:0] lane_in;
  logic [LANE_W-1:0] lane_out;
  logic             grant_s;
  logic             grant_k;

  // Key wins when alone or when it holds priority; state otherwise.
  assign grant_k = k_valid & (~s_valid | (rr_prio == RR_K));
  assign grant_s = s_valid & ~grant_k;
  assign s_ready = (state == IDLE) & grant_s;
  assign k_ready = (state == IDLE) & grant_k;
  assign busy    = (state != IDLE);

  assign base    = 7'(cnt) * 7'(LANE_W);
  assign lane_in = work[base +: LANE_W];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_byte u_sbox (
      .din  (lane_in[8*g +: 8]),
      .dout (lane_out[8*g +: 8])
    );
  end

  // The current beat's lane outputs merged into the work register.
  always_comb begin
    work_next = work;
    work_next[base +: LANE_W] = lane_out;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_prio  <= RR_K;
      cnt      <= '0;
      work     <= '0;
      s_result <= '0;
      k_result <= '0;
      s_done   <= 1'b0;
      k_done   <= 1'b0;
    end else begin
      s_done <= 1'b0;
      k_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            work    <= s_data;
            cnt     <= '0;
            state   <= RUN_S;
            rr_prio <= RR_K;
          end else if (k_valid && k_ready) begin
            work    <= {96'd0, k_data};
            cnt     <= '0;
            state   <= RUN_K;
            rr_prio <= RR_S;
          end
        end
        RUN_S: begin
          work <= work_next;
          if (cnt == LAST_S) begin
            state    <= IDLE;
            cnt      <= '0;
            s_result <= work_next;
            s_done   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN_K: begin
          work <= work_next;
          if (cnt == LAST_K) begin
            state    <= IDLE;
            cnt      <= '0;
            k_result <= work_next[31:0];
            k_done   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
